// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one sign-magnitude multiplier among NREQ requesters.
// state | meaning: IDLE = waiting for a request | MULT = product being registered | RESP = result held until accepted
module mult_scheduler #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [31:0]          rsp_result,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [15:0]          txn_count
);

  typedef enum logic [1:0] {IDLE, MULT, RESP} state_t;

  state_t          state;
  logic [2:0]      last_grant;
  logic [15:0]     op_a;
  logic [15:0]     op_b;
  logic [15:0]     count_q;
  logic [29:0]     product;

  logic            grant_any;
  logic [2:0]      grant_idx;
  logic [NREQ-1:0] grant_vec;
  logic [15:0]     sel_a;
  logic [15:0]     sel_b;

  // Round-robin: first look above last_grant, then wrap to the lowest index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i] && (3'(i) > last_grant)) begin
        grant_any    = 1'b1;
        grant_idx    = 3'(i);
        grant_vec[i] = 1'b1;
        sel_a        = req_a[16*i +: 16];
        sel_b        = req_b[16*i +: 16];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any    = 1'b1;
        grant_idx    = 3'(i);
        grant_vec[i] = 1'b1;
        sel_a        = req_a[16*i +: 16];
        sel_b        = req_b[16*i +: 16];
      end
    end
  end

  assign req_ready = (state == IDLE && !rst) ? grant_vec : '0;

  // The only multiplier: magnitudes of the latched operands.
  assign product   = 30'(op_a[14:0]) * 30'(op_b[14:0]);
  assign txn_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 3'(NREQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            state      <= MULT;
          end
        end
        MULT: begin
          rsp_result <= {op_a[15] ^ op_b[15], 1'b0, product};
          rsp_id     <= last_grant;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            count_q   <= count_q + 16'd1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
